// File: rtl/shift_seq.sv
// shift_seq: command-driven rotate / arithmetic-shift sequencer with
// valid/ready command and response handshakes.
// Define SHIFT_SEQ_ABORT_EN to add the abort input and rsp_aborted flag.
module shift_seq #(
   parameter  int WIDTH = 8,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CW-1:0]    cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [WIDTH-1:0] q,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic             abort,
   output logic             rsp_aborted,
`endif
   output logic             busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_ROR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [1:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] step_val;
   logic             accept;
   logic             abort_hit;

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign q         = q_q;
   assign rsp_data  = q_q;

`ifdef SHIFT_SEQ_ABORT_EN
   logic ab_q, ab_d;

   // Abort only counts while shifting; IDLE and DONE ignore it.
   assign abort_hit   = abort & (state_q == SHIFT);
   assign rsp_aborted = ab_q;

   // Aborted flag: set by an abort in SHIFT, cleared by the next accept.
   always_comb begin
      ab_d = ab_q;
      if (accept) begin
         ab_d = 1'b0;
      end else if (abort_hit) begin
         ab_d = 1'b1;
      end
   end

   // Aborted flag register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ab_q <= 1'b0;
      end else begin
         ab_q <= ab_d;
      end
   end
`else
   assign abort_hit = 1'b0;
`endif

   // One step of the latched operation applied to the live register.
   always_comb begin
      step_val = q_q;
      case (op_q)
         OP_ROL:  step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         OP_ROR:  step_val = {q_q[0], q_q[WIDTH-1:1]};
         OP_ASR:  step_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
         default: step_val = q_q;
      endcase
   end

   // Sequencer: accept in IDLE, step in SHIFT, wait for consumer in DONE.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               q_d     = cmd_data;
               op_d    = cmd_op;
               cnt_d   = cmd_count;
               state_d = (cmd_count != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (abort_hit) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               q_d   = step_val;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, data, op and step-counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed stimulus with a response scoreboard for shift_seq.
// Define SHIFT_SEQ_ABORT_EN to also exercise the abort path.
module tb_shift_seq;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_count = 3'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_ready = 1'b1;
   logic       cmd_ready;
   logic       rsp_valid;
   logic       busy;
   logic [7:0] rsp_data;
   logic [7:0] q;
`ifdef SHIFT_SEQ_ABORT_EN
   logic       abort = 1'b0;
   logic       rsp_aborted;
`endif

   typedef struct {
      logic [7:0] data;
      int         lat;
      logic       ab;
   } exp_t;

   exp_t expq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   lat = 0;
   logic prev_v = 1'b0;

   shift_seq #(.WIDTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_count   (cmd_count),
      .cmd_data    (cmd_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .q           (q),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort       (abort),
      .rsp_aborted (rsp_aborted),
`endif
      .busy        (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      n_chk++;
      $display("FAIL %s: bound expired or unexpected event", nm);
   endtask

   // Monitor: samples 1 time unit after the falling edge.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (reset) begin
            prev_v = 1'b0;
         end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
            if (rsp_valid && !prev_v) lat = cyc - acc_cyc + 1;
            if (rsp_valid && rsp_ready) begin
               if (expq.size() == 0) begin
                  fail("rsp_unexpected");
               end else begin
                  exp_t e;
                  e = expq.pop_front();
                  chk("rsp_data", rsp_data, e.data);
                  chk("rsp_latency", lat, e.lat);
`ifdef SHIFT_SEQ_ABORT_EN
                  chk("rsp_aborted", rsp_aborted, e.ab);
`endif
               end
            end
            prev_v = rsp_valid;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [2:0] cnt,
                        input logic [7:0] d, input logic [7:0] ed,
                        input int el, input logic eab, input bit push);
      int n;
      n = 0;
      @(negedge clock);
      while (!cmd_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!cmd_ready) begin
         fail("issue_timeout");
      end else begin
         cmd_op    = op;
         cmd_count = cnt;
         cmd_data  = d;
         cmd_valid = 1'b1;
         if (push) expq.push_back('{ed, el, eab});
         @(negedge clock);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq.size() != 0 || busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) fail("drain_timeout");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_q", q, 8'h00);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      @(negedge clock);
      reset = 1'b0;

      issue(2'b00, 3'd3, 8'h81, 8'h0C, 4, 1'b0, 1'b1);
      drain();
      issue(2'b10, 3'd2, 8'h90, 8'hE4, 3, 1'b0, 1'b1);
      drain();
      issue(2'b01, 3'd1, 8'h01, 8'h80, 2, 1'b0, 1'b1);
      drain();
      issue(2'b10, 3'd7, 8'h80, 8'hFF, 8, 1'b0, 1'b1);
      drain();
      issue(2'b10, 3'd7, 8'h40, 8'h00, 8, 1'b0, 1'b1);
      drain();
      issue(2'b00, 3'd7, 8'h01, 8'h80, 8, 1'b0, 1'b1);
      drain();
      issue(2'b11, 3'd5, 8'hA5, 8'hA5, 6, 1'b0, 1'b1);
      drain();
      issue(2'b00, 3'd0, 8'h3C, 8'h3C, 1, 1'b0, 1'b1);
      drain();

      // Command fields changing after accept must not matter.
      issue(2'b00, 3'd2, 8'h01, 8'h04, 3, 1'b0, 1'b1);
      cmd_op    = 2'b10;
      cmd_count = 3'd7;
      cmd_data  = 8'h80;
      drain();

      // Backpressure with a competing command held on the inputs.
      rsp_ready = 1'b0;
      issue(2'b01, 3'd0, 8'h5A, 8'h5A, 1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 2'b11;
         cmd_count = 3'd0;
         cmd_data  = 8'h33;
         #1;
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_data", rsp_data, 8'h5A);
         chk("bp_cmd_ready", cmd_ready, 0);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      #1;
      chk("retire_cmd_ready", cmd_ready, 1);
      chk("retire_rsp_valid", rsp_valid, 0);
      chk("retire_q", q, 8'h5A);
      chk("retire_busy", busy, 0);

      // Asynchronous reset in the middle of a run.
      issue(2'b00, 3'd7, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #3;
      chk("mid_busy", busy, 1);
      chk("mid_q", q, 8'hFF);
      reset = 1'b1;
      #1;
      chk("mid_rst_q", q, 8'h00);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clock);
      reset = 1'b0;
      issue(2'b00, 3'd3, 8'h81, 8'h0C, 4, 1'b0, 1'b1);
      drain();

`ifdef SHIFT_SEQ_ABORT_EN
      // Abort in the second SHIFT cycle skips that step.
      issue(2'b01, 3'd7, 8'h01, 8'h80, 3, 1'b1, 1'b1);
      @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      drain();
      // Abort held in IDLE is ignored; the accept clears the flag.
      abort = 1'b1;
      issue(2'b00, 3'd1, 8'h01, 8'h02, 2, 1'b0, 1'b1);
      abort = 1'b0;
      drain();
`endif

      repeat (2) @(negedge clock);
      chk("queue_empty", expq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
